// File: rtl/reg_file_2r1w.sv
// Two-read, one-write register file with registered read ports and a clear sequencer.
// Optional write-through forwarding to the read ports when REG_FILE_BYPASS_EN is defined.
module reg_file_2r1w #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned INIT_VALUE = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  output logic                  busy,
  input  logic                  w_en,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  ra_en,
  input  logic [ADDR_WIDTH-1:0] ra_addr,
  output logic [DATA_WIDTH-1:0] ra_data,
  output logic                  ra_valid,
  input  logic                  rb_en,
  input  logic [ADDR_WIDTH-1:0] rb_addr,
  output logic [DATA_WIDTH-1:0] rb_data,
  output logic                  rb_valid,
  output logic                  dbg_state
);

  localparam int unsigned           DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [DATA_WIDTH-1:0] INIT_WORD = DATA_WIDTH'(INIT_VALUE);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    user_wr;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    rd_ok;
  logic [DATA_WIDTH-1:0]   ra_word;
  logic [DATA_WIDTH-1:0]   rb_word;

  assign dbg_state = state;

  // Handshake: rX_valid is a one-cycle strobe, high in the cycle after an
  // accepted read (rX_en while not busy); there is no backpressure.
  // A user write is accepted only in IDLE and loses to a same-cycle clr.
  always_comb begin
    user_wr   = (state == ST_IDLE) && w_en && !clr;
    mem_we    = 1'b0;
    mem_waddr = w_addr;
    mem_wdata = w_data;
    if (state == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = cnt;
      mem_wdata = INIT_WORD;
    end else if (user_wr) begin
      mem_we    = 1'b1;
    end
    rd_ok = (state == ST_IDLE);
  end

  // Forwarding only ever sees user writes; clear writes happen while reads are blocked.
  always_comb begin
`ifdef REG_FILE_BYPASS_EN
    ra_word = (user_wr && (w_addr == ra_addr)) ? w_data : mem[ra_addr];
    rb_word = (user_wr && (w_addr == rb_addr)) ? w_data : mem[rb_addr];
`else
    ra_word = mem[ra_addr];
    rb_word = mem[rb_addr];
`endif
  end

  // Storage array carries no reset; its contents come from the clear sequencer.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_CLEAR;
      busy  <= 1'b1;
      cnt   <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clr) begin
            cnt <= '0;
          end else if (cnt == LAST_ADDR) begin
            cnt   <= '0;
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + ADDR_WIDTH'(1);
          end
        end
        ST_IDLE: begin
          if (clr) begin
            cnt   <= '0;
            state <= ST_CLEAR;
            busy  <= 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= ST_CLEAR;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ra_data  <= '0;
      ra_valid <= 1'b0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      ra_valid <= rd_ok && ra_en;
      rb_valid <= rd_ok && rb_en;
      if (rd_ok && ra_en) begin
        ra_data <= ra_word;
      end
      if (rd_ok && rb_en) begin
        rb_data <= rb_word;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench for reg_file_2r1w at default parameters; expected values are hand-computed.
// Honours REG_FILE_BYPASS_EN for the same-cycle read/write case.
module tb_reg_file_2r1w;

  logic       clk;
  logic       reset;
  logic       clr;
  logic       busy;
  logic       w_en;
  logic [2:0] w_addr;
  logic [7:0] w_data;
  logic       ra_en;
  logic [2:0] ra_addr;
  logic [7:0] ra_data;
  logic       ra_valid;
  logic       rb_en;
  logic [2:0] rb_addr;
  logic [7:0] rb_data;
  logic       rb_valid;
  logic       dbg_state;

  int n_checks;
  int n_fail;

  reg_file_2r1w dut (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .busy      (busy),
    .w_en      (w_en),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .ra_en     (ra_en),
    .ra_addr   (ra_addr),
    .ra_data   (ra_data),
    .ra_valid  (ra_valid),
    .rb_en     (rb_en),
    .rb_addr   (rb_addr),
    .rb_data   (rb_data),
    .rb_valid  (rb_valid),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clr     = 1'b0;
    w_en    = 1'b0;
    w_addr  = '0;
    w_data  = '0;
    ra_en   = 1'b0;
    ra_addr = '0;
    rb_en   = 1'b0;
    rb_addr = '0;
  endtask

  // Returns the number of edges until busy falls, capped at 40.
  task automatic wait_busy_low(output int n);
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic write_word(input logic [2:0] a, input logic [7:0] d);
    w_en   = 1'b1;
    w_addr = a;
    w_data = d;
    tick();
    w_en   = 1'b0;
  endtask

  task automatic read_ab(input logic [2:0] a, input logic [2:0] b);
    ra_en   = 1'b1;
    ra_addr = a;
    rb_en   = 1'b1;
    rb_addr = b;
    tick();
    ra_en   = 1'b0;
    rb_en   = 1'b0;
  endtask

  logic [7:0] exp_bypass;
  int         n;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle_inputs();
    reset = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_eq("rst_busy", busy, 1);
    check_eq("rst_ra_data", ra_data, 0);
    check_eq("rst_rb_data", rb_data, 0);
    check_eq("rst_ra_valid", ra_valid, 0);
    check_eq("rst_rb_valid", rb_valid, 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    check_eq("busy_after_deassert", busy, 1);
    wait_busy_low(n);
    check_eq("initial_clear_cycles", n, 8);

    // cleared contents, one-cycle valid pulses
    for (int i = 0; i < 8; i++) begin
      ra_en   = 1'b1;
      ra_addr = 3'(i);
      tick();
      check_eq($sformatf("init_read_data%0d", i), ra_data, 8'h00);
      check_eq($sformatf("init_read_valid%0d", i), ra_valid, 1);
      ra_en = 1'b0;
      tick();
      check_eq($sformatf("init_read_novalid%0d", i), ra_valid, 0);
    end

    write_word(3'd0, 8'hAA);
    write_word(3'd1, 8'hBB);
    write_word(3'd2, 8'hCC);
    read_ab(3'd0, 3'd2);
    check_eq("dual_read_a", ra_data, 8'hAA);
    check_eq("dual_read_b", rb_data, 8'hCC);
    check_eq("dual_valid_a", ra_valid, 1);
    check_eq("dual_valid_b", rb_valid, 1);
    read_ab(3'd1, 3'd1);
    check_eq("same_addr_a", ra_data, 8'hBB);
    check_eq("same_addr_b", rb_data, 8'hBB);

    // hold behaviour with read enable low
    ra_en   = 1'b1;
    ra_addr = 3'd0;
    tick();
    ra_en = 1'b0;
    check_eq("hold_first", ra_data, 8'hAA);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("hold_data%0d", i), ra_data, 8'hAA);
      check_eq($sformatf("hold_valid%0d", i), ra_valid, 0);
    end

    // same-cycle write and read of entry 3 (cleared to 0x00 earlier)
`ifdef REG_FILE_BYPASS_EN
    exp_bypass = 8'h55;
`else
    exp_bypass = 8'h00;
`endif
    w_en    = 1'b1;
    w_addr  = 3'd3;
    w_data  = 8'h55;
    ra_en   = 1'b1;
    ra_addr = 3'd3;
    rb_en   = 1'b1;
    rb_addr = 3'd3;
    tick();
    idle_inputs();
    check_eq("rw_same_cycle_a", ra_data, exp_bypass);
    check_eq("rw_same_cycle_b", rb_data, exp_bypass);
    read_ab(3'd3, 3'd3);
    check_eq("rw_next_cycle_a", ra_data, 8'h55);
    check_eq("rw_next_cycle_b", rb_data, 8'h55);

    // fill, then clr together with a write
    for (int i = 0; i < 8; i++) begin
      write_word(3'(i), 8'(8'h11 * (i + 1)));
    end
    read_ab(3'd7, 3'd4);
    check_eq("fill_read_a7", ra_data, 8'h88);
    check_eq("fill_read_b4", rb_data, 8'h55);
    clr    = 1'b1;
    w_en   = 1'b1;
    w_addr = 3'd5;
    w_data = 8'h77;
    tick();
    clr = 1'b0;
    check_eq("clr_busy", busy, 1);
    ra_en   = 1'b1;
    ra_addr = 3'd5;
    rb_en   = 1'b1;
    rb_addr = 3'd6;
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
      check_eq($sformatf("clr_no_valid_a%0d", n), ra_valid, 0);
      check_eq($sformatf("clr_no_valid_b%0d", n), rb_valid, 0);
      check_eq($sformatf("clr_held_a%0d", n), ra_data, 8'h88);
    end
    idle_inputs();
    check_eq("clr_cycles", n, 8);
    for (int i = 0; i < 8; i++) begin
      read_ab(3'(i), 3'(7 - i));
      check_eq($sformatf("post_clr_a%0d", i), ra_data, 8'h00);
      check_eq($sformatf("post_clr_b%0d", 7 - i), rb_data, 8'h00);
    end

    // reset in the middle of a clear
    write_word(3'd6, 8'h99);
    read_ab(3'd6, 3'd6);
    check_eq("pre_reset_a", ra_data, 8'h99);
    check_eq("pre_reset_b", rb_data, 8'h99);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_eq("mid_clear_busy", busy, 1);
    reset = 1'b1;
    #1;
    check_eq("async_rst_ra_data", ra_data, 0);
    check_eq("async_rst_rb_data", rb_data, 0);
    check_eq("async_rst_ra_valid", ra_valid, 0);
    check_eq("async_rst_busy", busy, 1);
    @(posedge clk);
    #1 reset = 1'b0;
    wait_busy_low(n);
    check_eq("restart_clear_cycles", n, 8);
    read_ab(3'd6, 3'd0);
    check_eq("after_restart_a6", ra_data, 8'h00);
    check_eq("after_restart_b0", rb_data, 8'h00);
    check_eq("after_restart_valid", ra_valid, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
